// File: rtl/seq_mul_pkg.sv
// Shared definitions for the seq_mul16 shift-and-add multiplier.
// Optional build macro: SEQ_MUL_ZERO_SKIP_EN (see seq_mul16.sv).
package seq_mul_pkg;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_STEPS = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_mul16_if.sv
// Start/busy/done handshake plus operand/product bus between the control
// unit (master) and the seq_mul16 multiplier (slave).
interface seq_mul16_if;
  import seq_mul_pkg::*;

  logic                     start;
  logic [MUL_WIDTH-1:0]     a;
  logic [MUL_WIDTH-1:0]     b;
  logic                     busy;
  logic                     done;
  logic [2*MUL_WIDTH-1:0]   product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/seq_mul16_alu16.sv
// ALU16: 16-bit adder reused by the multiplier as its per-step accumulator
// adder. Modeled as a plain add; synthesis maps it to the ripple chain.
module alu16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] x,
  output logic        cout
);

  // Sum with carry-out captured as the 17th bit
  assign {cout, x} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

// File: rtl/seq_mul16.sv
// seq_mul16: 16x16 unsigned shift-and-add multiplier, one step per cycle
// through ALU16; 17 cycles from accepted start to the done pulse.
// Optional build macro: SEQ_MUL_ZERO_SKIP_EN -- when defined, a start with a
// zero operand skips the iteration and reports product 0 one cycle later.
module seq_mul16
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  seq_mul16_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

  mul_state_t             state;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       hi;
  logic [WIDTH-1:0]       lo;
  logic [CNT_W-1:0]       cnt;
  logic [2*WIDTH-1:0]     product_r;

  logic [WIDTH-1:0]       alu_b;
  logic [WIDTH-1:0]       alu_x;
  logic                   alu_cout;
  logic [WIDTH-1:0]       hi_next;
  logic [WIDTH-1:0]       lo_next;

  // Partial product: add the multiplicand only when the current multiplier bit is set
  assign alu_b = lo[0] ? mcand : '0;

  alu16 u_alu16 (
    .a    (hi),
    .b    (alu_b),
    .cin  (1'b0),
    .x    (alu_x),
    .cout (alu_cout)
  );

  // Shift {cout, X, lo} right by one: carry lands in hi MSB, X LSB moves into lo
  assign hi_next = {alu_cout, alu_x[WIDTH-1:1]};
  assign lo_next = {alu_x[0], lo[WIDTH-1:1]};

  // Control FSM and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= MUL_IDLE;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      product_r <= '0;
    end else begin
      unique case (state)
        MUL_IDLE, MUL_DONE: begin
          if (bus.start) begin
            mcand <= bus.a;
            hi    <= '0;
            lo    <= bus.b;
            cnt   <= '0;
`ifdef SEQ_MUL_ZERO_SKIP_EN
            if ((bus.a == '0) || (bus.b == '0)) begin
              product_r <= '0;
              state     <= MUL_DONE;
            end else begin
              state <= MUL_RUN;
            end
`else
            state <= MUL_RUN;
`endif
          end else begin
            state <= MUL_IDLE;
          end
        end
        MUL_RUN: begin
          hi  <= hi_next;
          lo  <= lo_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            product_r <= {hi_next, lo_next};
            state     <= MUL_DONE;
          end
        end
        default: state <= MUL_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == MUL_RUN);
  assign bus.done    = (state == MUL_DONE);
  assign bus.product = product_r;

endmodule

// File: tb/tb_seq_mul16.sv
// Directed self-checking bench for seq_mul16. Cycle k means the interval
// after the k-th rising edge following the edge that samples start.
module tb_seq_mul16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_mul16_if bus ();

  seq_mul16 #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of cycle 1 with start dropped
  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%0b exp=0", bus.done);
    end
    checks++;
    if (bus.product !== 32'h0) begin
      errors++; $display("FAIL reset_product got=%h exp=00000000", bus.product);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    launch(16'd3, 16'd5);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      checks++;
      if (bus.busy !== (cyc <= 16)) begin
        errors++; $display("FAIL basic_busy cyc=%0d got=%0b exp=%0b", cyc, bus.busy, (cyc <= 16));
      end
      checks++;
      if (bus.done !== (cyc == 17)) begin
        errors++; $display("FAIL basic_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, (cyc == 17));
      end
      checks++;
      if (bus.product !== ((cyc >= 17) ? 32'h0000000F : 32'h0)) begin
        errors++; $display("FAIL basic_product cyc=%0d got=%h", cyc, bus.product);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_arith();
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic [31:0] pv [4];
    av[0] = 16'hFFFF; bv[0] = 16'hFFFF; pv[0] = 32'hFFFE0001;
    av[1] = 16'h8000; bv[1] = 16'h0002; pv[1] = 32'h00010000;
    av[2] = 16'h1234; bv[2] = 16'h5678; pv[2] = 32'h06260060;
    av[3] = 16'hFFFF; bv[3] = 16'h0001; pv[3] = 32'h0000FFFF;
    for (int i = 0; i < 4; i++) begin
      launch(av[i], bv[i]);
      repeat (16) @(negedge clk);
      checks++;
      if (bus.done !== 1'b1) begin
        errors++; $display("FAIL arith_done vec=%0d got=%0b exp=1", i, bus.done);
      end
      checks++;
      if (bus.product !== pv[i]) begin
        errors++; $display("FAIL arith_product vec=%0d got=%h exp=%h", i, bus.product, pv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start();
    launch(16'd7, 16'd9);
    repeat (3) @(negedge clk);
    bus.a     = 16'd1;
    bus.b     = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL ignore_busy got=%0b exp=1", bus.busy);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++; $display("FAIL ignore_done got=%0b exp=1", bus.done);
    end
    checks++;
    if (bus.product !== 32'h0000003F) begin
      errors++; $display("FAIL ignore_product got=%h exp=0000003f", bus.product);
    end
    for (int cyc = 18; cyc <= 25; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL ignore_extra cyc=%0d done=%0b busy=%0b exp=0/0", cyc, bus.done, bus.busy);
      end
      checks++;
      if (bus.product !== 32'h0000003F) begin
        errors++; $display("FAIL ignore_hold cyc=%0d got=%h exp=0000003f", cyc, bus.product);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    launch(16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy_before got=%0b exp=1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_state busy=%0b done=%0b exp=0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.product !== 32'h0) begin
      errors++; $display("FAIL abort_product got=%h exp=00000000", bus.product);
    end
    launch(16'd2, 16'd3);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      checks++;
      if (bus.done !== (cyc == 17)) begin
        errors++; $display("FAIL abort_rerun_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, (cyc == 17));
      end
      if (cyc < 17) @(negedge clk);
    end
    checks++;
    if (bus.product !== 32'h00000006) begin
      errors++; $display("FAIL abort_rerun_product got=%h exp=00000006", bus.product);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    launch(16'd10, 16'd10);
    repeat (16) @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 32'd100) begin
      errors++; $display("FAIL b2b_first done=%0b product=%h exp=1/00000064", bus.done, bus.product);
    end
    launch(16'h00FF, 16'h0100);
    for (int cyc = 1; cyc <= 17; cyc++) begin
      checks++;
      if (bus.busy !== (cyc <= 16)) begin
        errors++; $display("FAIL b2b_busy cyc=%0d got=%0b exp=%0b", cyc, bus.busy, (cyc <= 16));
      end
      checks++;
      if (bus.done !== (cyc == 17)) begin
        errors++; $display("FAIL b2b_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, (cyc == 17));
      end
      checks++;
      if (bus.product !== ((cyc == 17) ? 32'h0000FF00 : 32'd100)) begin
        errors++; $display("FAIL b2b_product cyc=%0d got=%h", cyc, bus.product);
      end
      if (cyc < 17) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    launch(16'h0000, 16'h1234);
`ifdef SEQ_MUL_ZERO_SKIP_EN
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_skip_cyc1 done=%0b busy=%0b exp=1/0", bus.done, bus.busy);
    end
    checks++;
    if (bus.product !== 32'h0) begin
      errors++; $display("FAIL zero_skip_product got=%h exp=00000000", bus.product);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL zero_skip_cyc2 done=%0b busy=%0b exp=0/0", bus.done, bus.busy);
    end
`else
    for (int cyc = 1; cyc <= 17; cyc++) begin
      checks++;
      if (bus.done !== (cyc == 17)) begin
        errors++; $display("FAIL zero_done cyc=%0d got=%0b exp=%0b", cyc, bus.done, (cyc == 17));
      end
      if (cyc < 17) @(negedge clk);
    end
    checks++;
    if (bus.product !== 32'h0) begin
      errors++; $display("FAIL zero_product got=%h exp=00000000", bus.product);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;
    test_reset();
    test_basic();
    test_arith();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
